// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the sys_ctrl_mc system controller: command codes,
// FSM state encoding, err_flags bit positions and a state classification helper.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR       = 8'hAA;
  localparam logic [7:0] CMD_RD       = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP   = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;
  localparam logic [7:0] CMD_BURST_WR = 8'hEE;

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StOpA,
    StOpB,
    StFun,
    StAluRun,
    StBwAddr,
    StBwCnt,
    StBwData
  } state_e;

  // err_flags bit positions
  localparam int unsigned ERR_BAD_CMD    = 0;
  localparam int unsigned ERR_FIFO_STALL = 1;
  localparam int unsigned ERR_RX_OVERRUN = 2;

  // States in which a frame has started but more RX bytes are still expected.
  function automatic logic is_partial(state_e s);
    return !(s inside {StIdle, StRdWait, StAluRun});
  endfunction

endpackage

// File: rtl/sys_ctrl_rsp_fifo.sv
// Response FIFO for sys_ctrl_mc.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i write side;
// pop_i/rdata_o read side (rdata_o shows the head entry); empty_o; free_o = free slots.
// Push and pop may occur in the same cycle. The caller never pushes when full.
module sys_ctrl_rsp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic [CntW-1:0]  free_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so the pointers wrap naturally.
    if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_i && !pop_i)      count_d = count_q + CntW'(1);
    else if (!push_i && pop_i) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign free_o  = CntW'(Depth) - count_q;

endmodule

// File: rtl/sys_ctrl_mc.sv
// sys_ctrl_mc: command decoder between the UART byte streams and the regfile/ALU.
// Frames: AA addr data (write), BB addr (read), CC opA opB fun (ALU with operands),
// DD fun (ALU on existing operands), EE addr N data*N (burst write).
// Ports: CLK/RST (async active-low); RX_P_DATA/RX_D_VLD byte input; WrEn/RdEn/Address/
// Wr_D/RdDATA/RdDATA_VLD regfile side; Gate_EN/ALU_EN/ALU_FUN/ALU_OUT/OUT_Valid ALU side;
// Busy/TX_P_DATA/TX_D_VLD UART TX side; err_flags sticky {rx_overrun, fifo_full_stall, bad_cmd}.
// Optional macro FRAME_TIMEOUT_EN: abort a partial frame after TIMEOUT_CYC idle cycles.
module sys_ctrl_mc
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR        = 4,
  parameter int unsigned ALU_WIDTH   = 2 * DATA_WIDTH,
  parameter int unsigned RSP_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR-1:0]       Address,
  output logic [DATA_WIDTH-1:0] Wr_D,
  input  logic [DATA_WIDTH-1:0] RdDATA,
  input  logic                  RdDATA_VLD,
  output logic                  Gate_EN,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_Valid,
  input  logic                  Busy,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic [2:0]            err_flags
);

  localparam int unsigned NB   = (ALU_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned ResW = NB * DATA_WIDTH;

  state_e state_q, state_d;

  logic [ADDR-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_hold_q, rd_hold_d;   // read addr latched, waiting for FIFO space
  logic                  fun_hold_q, fun_hold_d; // fun latched, waiting for NB free slots
  logic [ResW-1:0]       res_q, res_d;
  logic                  alu_push_q, alu_push_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR-1:0]       address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_d_q, wr_d_d;
  logic                  gate_en_q, gate_en_d;
  logic                  alu_en_q, alu_en_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  tx_pend_q, tx_pend_d;
  logic                  saw_busy_q, saw_busy_d;
  logic [2:0]            err_q, err_d;

  logic                  fifo_push, fifo_pop, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_wdata, fifo_rdata;
  logic [CntW-1:0]       fifo_free;
  logic                  rd_space, alu_space, timeout_hit, is_cmd, byte_ok;

  assign rd_space  = fifo_free >= CntW'(1);
  assign alu_space = fifo_free >= CntW'(NB);
  assign fifo_pop  = !fifo_empty && !Busy && !tx_pend_q;

  always_comb begin
    is_cmd = 1'b0;
    case (RX_P_DATA)
      DATA_WIDTH'(CMD_WR), DATA_WIDTH'(CMD_RD), DATA_WIDTH'(CMD_ALU_OP),
      DATA_WIDTH'(CMD_ALU_NOP), DATA_WIDTH'(CMD_BURST_WR): is_cmd = 1'b1;
      default: is_cmd = 1'b0;
    endcase
  end

  // A held read/ALU frame is complete; it is only waiting for FIFO space.
  always_comb begin
    byte_ok = 1'b1;
    case (state_q)
      StRdAddr:           byte_ok = !rd_hold_q;
      StFun:              byte_ok = !fun_hold_q;
      StRdWait, StAluRun: byte_ok = 1'b0;
      default:            byte_ok = 1'b1;
    endcase
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            waiting_byte;

  assign waiting_byte = is_partial(state_q) && byte_ok;
  assign timeout_hit  = waiting_byte && !RX_D_VLD && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = tmo_q + TmoW'(1);
    if (RX_D_VLD || !waiting_byte || timeout_hit) tmo_d = '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: if (RX_D_VLD) begin
          case (RX_P_DATA)
            DATA_WIDTH'(CMD_WR):       state_d = StWrAddr;
            DATA_WIDTH'(CMD_RD):       state_d = StRdAddr;
            DATA_WIDTH'(CMD_ALU_OP):   state_d = StOpA;
            DATA_WIDTH'(CMD_ALU_NOP):  state_d = StFun;
            DATA_WIDTH'(CMD_BURST_WR): state_d = StBwAddr;
            default:                   state_d = StIdle;
          endcase
        end
        StWrAddr: if (RX_D_VLD) state_d = StWrData;
        StWrData: if (RX_D_VLD) state_d = StIdle;
        StRdAddr: if (rd_hold_q ? rd_space : (RX_D_VLD && rd_space)) state_d = StRdWait;
        StRdWait: if (RdDATA_VLD) state_d = StIdle;
        StOpA:    if (RX_D_VLD) state_d = StOpB;
        StOpB:    if (RX_D_VLD) state_d = StFun;
        StFun:    if (fun_hold_q ? alu_space : (RX_D_VLD && alu_space)) state_d = StAluRun;
        StAluRun: if (alu_push_q && idx_q == IdxW'(NB - 1)) state_d = StIdle;
        StBwAddr: if (RX_D_VLD) state_d = StBwCnt;
        StBwCnt:  if (RX_D_VLD) state_d = (RX_P_DATA == '0) ? StIdle : StBwData;
        StBwData: if (RX_D_VLD && cnt_q == DATA_WIDTH'(1)) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs and datapath next values (all outputs are registered)
  always_comb begin
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rd_hold_d  = rd_hold_q;
    fun_hold_d = fun_hold_q;
    res_d      = res_q;
    alu_push_d = alu_push_q;
    idx_d      = idx_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    address_d  = address_q;
    wr_d_d     = wr_d_q;
    gate_en_d  = gate_en_q;
    alu_fun_d  = alu_fun_q;
    err_d      = err_q;
    fifo_push  = 1'b0;
    fifo_wdata = '0;

    if (RX_D_VLD && !byte_ok) err_d[ERR_RX_OVERRUN] = 1'b1;

    if (timeout_hit) begin
      rd_hold_d            = 1'b0;
      fun_hold_d           = 1'b0;
      gate_en_d            = 1'b0;
      err_d[ERR_BAD_CMD]   = 1'b1;
    end else begin
      case (state_q)
        StIdle: if (RX_D_VLD && !is_cmd) err_d[ERR_BAD_CMD] = 1'b1;
        StWrAddr, StBwAddr: if (RX_D_VLD) addr_d = RX_P_DATA[ADDR-1:0];
        StWrData: if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = addr_q;
          wr_d_d    = RX_P_DATA;
        end
        StRdAddr: begin
          if (rd_hold_q) begin
            if (rd_space) begin
              rd_en_d   = 1'b1;
              address_d = addr_q;
              rd_hold_d = 1'b0;
            end
          end else if (RX_D_VLD) begin
            addr_d = RX_P_DATA[ADDR-1:0];
            if (rd_space) begin
              rd_en_d   = 1'b1;
              address_d = RX_P_DATA[ADDR-1:0];
            end else begin
              rd_hold_d               = 1'b1;
              err_d[ERR_FIFO_STALL]   = 1'b1;
            end
          end
        end
        StRdWait: if (RdDATA_VLD) begin
          fifo_push  = 1'b1;
          fifo_wdata = RdDATA;
        end
        StOpA, StOpB: if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = (state_q == StOpA) ? ADDR'(0) : ADDR'(1);
          wr_d_d    = RX_P_DATA;
        end
        StFun: begin
          if (fun_hold_q) begin
            if (alu_space) begin
              alu_en_d   = 1'b1;
              fun_hold_d = 1'b0;
            end
          end else if (RX_D_VLD) begin
            alu_fun_d = RX_P_DATA[3:0];
            gate_en_d = 1'b1;
            if (alu_space) begin
              alu_en_d = 1'b1;
            end else begin
              fun_hold_d            = 1'b1;
              err_d[ERR_FIFO_STALL] = 1'b1;
            end
          end
        end
        StAluRun: begin
          if (!alu_push_q) begin
            if (OUT_Valid) begin
              res_d      = ResW'(ALU_OUT);
              alu_push_d = 1'b1;
              idx_d      = '0;
            end
          end else begin
            // Result bytes go out LSB-first, one per cycle.
            fifo_push  = 1'b1;
            fifo_wdata = res_q[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];
            if (idx_q == IdxW'(NB - 1)) begin
              alu_push_d = 1'b0;
              gate_en_d  = 1'b0;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        StBwCnt: if (RX_D_VLD) begin
          if (RX_P_DATA == '0) err_d[ERR_BAD_CMD] = 1'b1;
          else                 cnt_d = RX_P_DATA;
        end
        StBwData: if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = addr_q;
          wr_d_d    = RX_P_DATA;
          addr_d    = addr_q + ADDR'(1);
          cnt_d     = cnt_q - DATA_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // TX drain: one byte per Busy rise/fall cycle of the UART.
  always_comb begin
    tx_vld_d   = 1'b0;
    tx_data_d  = tx_data_q;
    tx_pend_d  = tx_pend_q;
    saw_busy_d = saw_busy_q;
    if (fifo_pop) begin
      tx_vld_d   = 1'b1;
      tx_data_d  = fifo_rdata;
      tx_pend_d  = 1'b1;
      saw_busy_d = 1'b0;
    end else if (tx_pend_q) begin
      if (Busy) begin
        saw_busy_d = 1'b1;
      end else if (saw_busy_q) begin
        tx_pend_d  = 1'b0;
        saw_busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_hold_q  <= 1'b0;
      fun_hold_q <= 1'b0;
      res_q      <= '0;
      alu_push_q <= 1'b0;
      idx_q      <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      address_q  <= '0;
      wr_d_q     <= '0;
      gate_en_q  <= 1'b0;
      alu_en_q   <= 1'b0;
      alu_fun_q  <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      tx_pend_q  <= 1'b0;
      saw_busy_q <= 1'b0;
      err_q      <= '0;
    end else begin
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_hold_q  <= rd_hold_d;
      fun_hold_q <= fun_hold_d;
      res_q      <= res_d;
      alu_push_q <= alu_push_d;
      idx_q      <= idx_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      address_q  <= address_d;
      wr_d_q     <= wr_d_d;
      gate_en_q  <= gate_en_d;
      alu_en_q   <= alu_en_d;
      alu_fun_q  <= alu_fun_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      tx_pend_q  <= tx_pend_d;
      saw_busy_q <= saw_busy_d;
      err_q      <= err_d;
    end
  end

  sys_ctrl_rsp_fifo #(
    .Width (DATA_WIDTH),
    .Depth (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .free_o  (fifo_free)
  );

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = address_q;
  assign Wr_D      = wr_d_q;
  assign Gate_EN   = gate_en_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign err_flags = err_q;

endmodule

// File: tb/tb_sys_ctrl_mc.sv
// Scoreboard bench for sys_ctrl_mc: stimulus pushes expected writes, ALU function codes
// and TX bytes into queues; monitors pop and compare whenever the DUT strobes.
module tb_sys_ctrl_mc;

  localparam int unsigned TMO = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic        WrEn, RdEn, Gate_EN, ALU_EN, TX_D_VLD;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  Wr_D, TX_P_DATA;
  logic [7:0]  RdDATA = '0;
  logic        RdDATA_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_Valid = 1'b0;
  logic        Busy;
  logic [2:0]  err_flags;

  logic        busy_hold = 1'b0;
  int          uart_cnt = 0;
  int          tx_count = 0;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] alu_result = '0;
  int          alu_delay = 1;
  logic [7:0]  mem [16];

  logic [11:0] wr_q [$];
  logic [7:0]  tx_q [$];
  logic [3:0]  fun_q [$];

  assign Busy = busy_hold | (uart_cnt != 0);

  always #5 CLK = ~CLK;

  sys_ctrl_mc #(
    .DATA_WIDTH  (8),
    .ADDR        (4),
    .ALU_WIDTH   (16),
    .RSP_DEPTH   (4),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .WrEn       (WrEn),
    .RdEn       (RdEn),
    .Address    (Address),
    .Wr_D       (Wr_D),
    .RdDATA     (RdDATA),
    .RdDATA_VLD (RdDATA_VLD),
    .Gate_EN    (Gate_EN),
    .ALU_EN     (ALU_EN),
    .ALU_FUN    (ALU_FUN),
    .ALU_OUT    (ALU_OUT),
    .OUT_Valid  (OUT_Valid),
    .Busy       (Busy),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VLD   (TX_D_VLD),
    .err_flags  (err_flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Write / TX monitor plus regfile storage and UART busy model.
  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn) begin
        mem[Address] = Wr_D;
        if (wr_q.size() == 0) check("unexpected_wren", {20'h0, Address, Wr_D}, 32'hFFFF_FFFF);
        else                  check("wr_addr_data", {20'h0, Address, Wr_D}, {20'h0, wr_q.pop_front()});
      end
      if (uart_cnt > 0) uart_cnt--;
      if (TX_D_VLD) begin
        tx_count++;
        uart_cnt = 3;
        if (tx_q.size() == 0) check("unexpected_tx", {24'h0, TX_P_DATA}, 32'hFFFF_FFFF);
        else                  check("tx_byte", {24'h0, TX_P_DATA}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  // Regfile read responder: data returned one cycle after RdEn.
  initial begin
    logic [3:0] ra;
    forever begin
      @(negedge CLK);
      if (RST && RdEn) begin
        ra = Address;
        @(posedge CLK); #1;
        RdDATA     = mem[ra];
        RdDATA_VLD = 1'b1;
        @(posedge CLK); #1;
        RdDATA_VLD = 1'b0;
      end
    end
  end

  // ALU responder and function-code monitor.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST && ALU_EN) begin
        if (fun_q.size() == 0) check("unexpected_alu_en", {28'h0, ALU_FUN}, 32'hFFFF_FFFF);
        else                   check("alu_fun", {28'h0, ALU_FUN}, {28'h0, fun_q.pop_front()});
        check("gate_en_during_alu", {31'h0, Gate_EN}, 32'h1);
        repeat (alu_delay) @(posedge CLK);
        #1;
        ALU_OUT   = alu_result;
        OUT_Valid = 1'b1;
        @(posedge CLK); #1;
        OUT_Valid = 1'b0;
      end
    end
  end

  initial begin
    logic [3:0] rd_addr [4];
    logic [7:0] rd_exp  [4];
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rd_addr[0] = 4'h5; rd_exp[0] = 8'h3C;
    rd_addr[1] = 4'hE; rd_exp[1] = 8'hA1;
    rd_addr[2] = 4'hF; rd_exp[2] = 8'hA2;
    rd_addr[3] = 4'h1; rd_exp[3] = 8'h34;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_strobes", {27'h0, WrEn, RdEn, ALU_EN, Gate_EN, TX_D_VLD}, 32'h0);
    check("rst_addr_wrd", {20'h0, Address, Wr_D}, 32'h0);
    check("rst_fun_tx", {20'h0, ALU_FUN, TX_P_DATA}, 32'h0);
    check("rst_err", {29'h0, err_flags}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(2);

    // Single write
    wr_q.push_back({4'h5, 8'h3C});
    send(8'hAA); send(8'h05); send(8'h3C);
    idle(6);
    check("no_tx_after_write", tx_count, 0);

    // Single read
    tx_q.push_back(8'h3C);
    send(8'hBB); send(8'h05);
    idle(15);

    // ALU with operands, two result bytes LSB-first
    wr_q.push_back({4'h0, 8'h12});
    wr_q.push_back({4'h1, 8'h34});
    fun_q.push_back(4'h0);
    alu_result = 16'h0046;
    alu_delay  = 1;
    tx_q.push_back(8'h46);
    tx_q.push_back(8'h00);
    send(8'hCC); send(8'h12); send(8'h34); send(8'h00);
    idle(25);
    check("gate_en_low_after_alu", {31'h0, Gate_EN}, 32'h0);
    check("tx_count_after_alu", tx_count, 3);

    // Burst write with address wrap
    wr_q.push_back({4'hE, 8'hA1});
    wr_q.push_back({4'hF, 8'hA2});
    wr_q.push_back({4'h0, 8'hA3});
    send(8'hEE); send(8'h0E); send(8'h03); send(8'hA1); send(8'hA2); send(8'hA3);
    idle(6);
    check("err_clean_before_stall", {29'h0, err_flags}, 32'h0);

    // Fill the FIFO while TX is busy, then a fifth read stalls
    busy_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(rd_exp[i]);
      send(8'hBB); send({4'h0, rd_addr[i]});
      idle(5);
    end
    tx_q.push_back(8'hA3);
    send(8'hBB); send(8'h00);
    idle(6);
    check("stall_flag", {29'h0, err_flags}, 32'h2);
    check("no_tx_while_busy", tx_count, 3);
    busy_hold = 1'b0;
    idle(90);
    check("tx_count_after_drain", tx_count, 8);

    // Unknown command
    send(8'h77);
    idle(6);
    check("bad_cmd_flag", {29'h0, err_flags}, 32'h3);

    // Byte arriving during ALU_RUN is dropped and flagged
    fun_q.push_back(4'h5);
    alu_result = 16'h1234;
    alu_delay  = 6;
    tx_q.push_back(8'h34);
    tx_q.push_back(8'h12);
    send(8'hDD); send(8'h05); send(8'h11);
    idle(40);
    check("overrun_flag", {29'h0, err_flags}, 32'h7);
    check("tx_count_after_overrun", tx_count, 10);

`ifdef FRAME_TIMEOUT_EN
    // Partial write frame times out; the following frame decodes from IDLE
    send(8'hAA); send(8'h05);
    idle(TMO + 10);
    wr_q.push_back({4'h6, 8'h55});
    send(8'hAA); send(8'h06); send(8'h55);
    idle(6);
`endif

    check("wr_queue_drained", wr_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    check("alu_queue_drained", fun_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
